// File: rtl/mulu_sweep_checker.sv
// Built-in self-test sequencer for an unsigned multiplier: sweeps every (x, y)
// operand pair, compares the returned product against x*y and records the result.
module mulu_sweep_checker #(
  parameter int X_WIDTH = 2,
  parameter int Y_WIDTH = 2,
  parameter int P_WIDTH = X_WIDTH + Y_WIDTH,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [X_WIDTH-1:0] x,
  output logic [Y_WIDTH-1:0] y,
  input  logic [P_WIDTH-1:0] p,
  input  logic               rdy,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [7:0]         err_cnt,
  output logic               fail_valid,
  output logic [X_WIDTH-1:0] fail_x,
  output logic [Y_WIDTH-1:0] fail_y
);

  localparam int FULL_W = X_WIDTH + Y_WIDTH;
  localparam int WC_W   = $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] SETTLE_LAST = WC_W'(SETTLE - 1);
  // A missed pair occupies TIMEOUT cycles in total, the CHECK cycle included.
  localparam logic [WC_W-1:0] MISS_AT     = WC_W'(TIMEOUT - 2);

  typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;

  state_t             state, state_nxt;
  logic [WC_W-1:0]    wait_cnt;
  logic [P_WIDTH-1:0] p_q;
  logic               miss;
  logic [FULL_W-1:0]  full_prod;
  logic               capture, timeout, last_pair, mismatch;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign full_prod = FULL_W'(x) * FULL_W'(y);
  assign capture   = (state == WAIT) && (wait_cnt >= SETTLE_LAST) && rdy;
  assign timeout   = (state == WAIT) && !capture && (wait_cnt == MISS_AT);
  assign last_pair = (&x) && (&y);
  assign mismatch  = (state == CHECK) && (miss || (p_q != P_WIDTH'(full_prod)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = WAIT;
      WAIT:    if (capture || timeout) state_nxt = CHECK;
      CHECK:   state_nxt = last_pair ? DONE : WAIT;
      DONE:    if (start) state_nxt = WAIT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == WAIT) || (state == CHECK);
    pass = done && (err_cnt == 8'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x          <= '0;
      y          <= '0;
      wait_cnt   <= '0;
      p_q        <= '0;
      miss       <= 1'b0;
      err_cnt    <= 8'd0;
      done       <= 1'b0;
      fail_valid <= 1'b0;
      fail_x     <= '0;
      fail_y     <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            x          <= '0;
            y          <= '0;
            wait_cnt   <= '0;
            err_cnt    <= 8'd0;
            done       <= 1'b0;
            fail_valid <= 1'b0;
            fail_x     <= '0;
            fail_y     <= '0;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt + WC_W'(1);
          if (capture) begin
            p_q  <= p;
            miss <= 1'b0;
          end else if (timeout) begin
            miss <= 1'b1;
          end
        end
        CHECK: begin
          if (mismatch) begin
            err_cnt <= sat_inc(err_cnt);
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_x     <= x;
              fail_y     <= y;
            end
          end
          // y is the inner loop; operands freeze on the final pair.
          if (last_pair) begin
            done <= 1'b1;
          end else begin
            wait_cnt <= '0;
            if (&y) begin
              y <= '0;
              x <= x + X_WIDTH'(1);
            end else begin
              y <= y + Y_WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
